// File: rtl/snoop_bus_arbiter_if.sv
// Two-core snoop bus bundle: core requests, snoop broadcast/response, memory handshake.
// No storage; pure signal grouping.
// Flow control is level-based: req held by cores, snoop_ack/mem_ready complete phases.
interface snoop_bus_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic [1:0]        req;
   logic [ADDR_W-1:0] req_addr0;
   logic [ADDR_W-1:0] req_addr1;
   logic [1:0]        req_type0;
   logic [1:0]        req_type1;
   logic [1:0]        gnt;
   logic              bus_valid;
   logic [ADDR_W-1:0] bus_addr;
   logic [1:0]        bus_type;
   logic              bus_src;
   logic              snoop_ack;
   logic              snoop_hit;
   logic              snoop_dirty;
   logic              mem_req;
   logic              mem_we;
   logic              mem_ready;
   logic [1:0]        done;
   logic              resp_shared;
   logic              busy;
   logic              err_timeout;

   modport master (
      input  req, req_addr0, req_addr1, req_type0, req_type1,
      input  snoop_ack, snoop_hit, snoop_dirty, mem_ready,
      output gnt, bus_valid, bus_addr, bus_type, bus_src,
      output mem_req, mem_we, done, resp_shared, busy, err_timeout
   );

   modport slave (
      output req, req_addr0, req_addr1, req_type0, req_type1,
      output snoop_ack, snoop_hit, snoop_dirty, mem_ready,
      input  gnt, bus_valid, bus_addr, bus_type, bus_src,
      input  mem_req, mem_we, done, resp_shared, busy, err_timeout
   );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter for two snooping cores driving a shared bus and memory port.
// Latency: grant->snoop broadcast 1 cycle; done pulses one cycle after the last phase.
// Backpressure: waits on snoop_ack (watchdog-bounded) and on mem_ready (unbounded).
module snoop_bus_arbiter #(
   parameter int ADDR_W        = 32,
   parameter int SNOOP_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                reset,
   snoop_bus_arbiter_if.master sb
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SNOOP = 3'd1;
   localparam logic [2:0] FLUSH = 3'd2;
   localparam logic [2:0] MEM   = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [1:0] BUS_RD    = 2'b00;
   localparam logic [1:0] BUS_RDX   = 2'b01;
   localparam logic [1:0] BUS_UPGR  = 2'b10;
   localparam logic [1:0] WRITEBACK = 2'b11;

   localparam logic [3:0] TIMEOUT_CNT = 4'(SNOOP_TIMEOUT);

   logic [2:0]        state;
   logic              src_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        type_q;
   logic              last_served;
   logic [1:0]        mask;
   logic [3:0]        watchdog;
   logic              err_q;
   logic              hit_q;

   logic [1:0]        eff_req;
   logic              win;
   logic [ADDR_W-1:0] win_addr;
   logic [1:0]        win_type;
   logic [3:0]        watchdog_inc;
   logic              timeout;
   logic [1:0]        src_onehot;

   // The just-served core is hidden for one IDLE cycle so a stale req is not re-granted.
   assign eff_req      = sb.req & ~mask;
   assign win          = (eff_req == 2'b11) ? ~last_served : eff_req[1];
   assign win_addr     = win ? sb.req_addr1 : sb.req_addr0;
   assign win_type     = win ? sb.req_type1 : sb.req_type0;
   assign watchdog_inc = watchdog + 4'd1;
   assign timeout      = (watchdog_inc == TIMEOUT_CNT);
   assign src_onehot   = {src_q, ~src_q};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         src_q       <= 1'b0;
         addr_q      <= '0;
         type_q      <= 2'b00;
         last_served <= 1'b1;
         mask        <= 2'b00;
         watchdog    <= 4'd0;
         err_q       <= 1'b0;
         hit_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               mask <= 2'b00;
               if (|eff_req) begin
                  src_q    <= win;
                  addr_q   <= win_addr;
                  type_q   <= win_type;
                  hit_q    <= 1'b0;
                  watchdog <= 4'd0;
                  state    <= (win_type == WRITEBACK) ? MEM : SNOOP;
               end
            end
            SNOOP: begin
               if (sb.snoop_ack) begin
                  hit_q <= sb.snoop_hit;
                  if (sb.snoop_dirty)
                     state <= FLUSH;
                  else if ((type_q == BUS_UPGR) || (sb.snoop_hit && (type_q == BUS_RDX)))
                     state <= DONE;
                  else
                     state <= MEM;
               end else begin
                  watchdog <= watchdog_inc;
                  // Silent snooper: treat as a miss and fetch from memory.
                  if (timeout) begin
                     err_q <= 1'b1;
                     state <= MEM;
                  end
               end
            end
            FLUSH, MEM: begin
               if (sb.mem_ready)
                  state <= DONE;
            end
            DONE: begin
               last_served <= src_q;
               mask        <= src_onehot;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sb.gnt         = (state != IDLE) ? src_onehot : 2'b00;
   assign sb.bus_valid   = (state == SNOOP);
   assign sb.bus_addr    = addr_q;
   assign sb.bus_type    = type_q;
   assign sb.bus_src     = src_q;
   assign sb.mem_req     = (state == FLUSH) || (state == MEM);
   assign sb.mem_we      = (state == FLUSH) || ((state == MEM) && (type_q == WRITEBACK));
   assign sb.done        = (state == DONE) ? src_onehot : 2'b00;
   assign sb.resp_shared = (state == DONE) && (type_q == BUS_RD) && hit_q;
   assign sb.busy        = (state != IDLE);
   assign sb.err_timeout = err_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Cycle-table bench for snoop_bus_arbiter: per-cycle inputs and expected outputs,
// with expectations queued at drive time and popped when the outputs are sampled.
module tb_snoop_bus_arbiter;

   localparam logic [31:0] A0 = 32'h0000_0040;
   localparam logic [31:0] A1 = 32'h0000_0080;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   snoop_bus_arbiter_if #(.ADDR_W(32)) sb();

   snoop_bus_arbiter #(.ADDR_W(32), .SNOOP_TIMEOUT(15)) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sb)
   );

   typedef struct packed {
      logic [1:0]  gnt;
      logic        bus_valid;
      logic [31:0] bus_addr;
      logic [1:0]  bus_type;
      logic        bus_src;
      logic        mem_req;
      logic        mem_we;
      logic [1:0]  done;
      logic        resp_shared;
      logic        busy;
      logic        err;
   } exp_t;

   typedef struct {
      string      name;
      logic       rst_n;
      logic [1:0] req;
      logic [1:0] t0;
      logic [1:0] t1;
      logic       ack;
      logic       hit;
      logic       dirty;
      logic       rdy;
      exp_t       e;
   } vec_t;

   vec_t tbl[$];
   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic exp_t idle(input logic err);
      exp_t e;
      e     = '0;
      e.err = err;
      return e;
   endfunction

   function automatic exp_t act(input logic src, input logic [1:0] ty, input logic bv,
                                input logic mr, input logic mw, input logic [1:0] dn,
                                input logic rs, input logic err);
      exp_t e;
      e.gnt         = src ? 2'b10 : 2'b01;
      e.bus_valid   = bv;
      e.bus_addr    = src ? A1 : A0;
      e.bus_type    = ty;
      e.bus_src     = src;
      e.mem_req     = mr;
      e.mem_we      = mw;
      e.done        = dn;
      e.resp_shared = rs;
      e.busy        = 1'b1;
      e.err         = err;
      return e;
   endfunction

   function automatic vec_t mk(input string nm, input logic rn, input logic [1:0] req,
                               input logic [1:0] t0, input logic [1:0] t1, input logic ack,
                               input logic hit, input logic dirty, input logic rdy, input exp_t e);
      vec_t v;
      v.name = nm; v.rst_n = rn; v.req = req; v.t0 = t0; v.t1 = t1;
      v.ack = ack; v.hit = hit; v.dirty = dirty; v.rdy = rdy; v.e = e;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      exp_t got;
      exp_t want;
      @(negedge clk);
      reset          = v.rst_n;
      sb.req         = v.req;
      sb.req_type0   = v.t0;
      sb.req_type1   = v.t1;
      sb.snoop_ack   = v.ack;
      sb.snoop_hit   = v.hit;
      sb.snoop_dirty = v.dirty;
      sb.mem_ready   = v.rdy;
      sb_q.push_back(v.e);
      #1;
      got  = {sb.gnt, sb.bus_valid, sb.bus_addr, sb.bus_type, sb.bus_src, sb.mem_req,
              sb.mem_we, sb.done, sb.resp_shared, sb.busy, sb.err_timeout};
      want = sb_q.pop_front();
      // Latched bus fields are only meaningful while a transaction is open or just after reset.
      if (v.rst_n && !want.busy) begin
         got.bus_addr = '0;
         got.bus_type = 2'b00;
         got.bus_src  = 1'b0;
      end
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got gnt=%b bv=%b addr=%h ty=%0d src=%b mreq=%b mwe=%b done=%b rs=%b busy=%b err=%b, want gnt=%b bv=%b addr=%h ty=%0d src=%b mreq=%b mwe=%b done=%b rs=%b busy=%b err=%b",
                  v.name, got.gnt, got.bus_valid, got.bus_addr, got.bus_type, got.bus_src,
                  got.mem_req, got.mem_we, got.done, got.resp_shared, got.busy, got.err,
                  want.gnt, want.bus_valid, want.bus_addr, want.bus_type, want.bus_src,
                  want.mem_req, want.mem_we, want.done, want.resp_shared, want.busy, want.err);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL sim_time_limit: got still running, want finished");
      $fatal(1, "time limit");
   end

   initial begin
      reset          = 1'b0;
      sb.req         = 2'b00;
      sb.req_addr0   = A0;
      sb.req_addr1   = A1;
      sb.req_type0   = 2'b00;
      sb.req_type1   = 2'b00;
      sb.snoop_ack   = 1'b0;
      sb.snoop_hit   = 1'b0;
      sb.snoop_dirty = 1'b0;
      sb.mem_ready   = 1'b0;

      tbl.push_back(mk("reset",        0, 2'b00, 2'd0, 2'd0, 0, 0, 0, 0, idle(0)));
      tbl.push_back(mk("idle0",        1, 2'b00, 2'd0, 2'd0, 0, 0, 0, 0, idle(0)));
      // BusRd shared hit; req dropped mid-transaction, then held stale across done
      tbl.push_back(mk("rd_req",       1, 2'b01, 2'd0, 2'd0, 0, 0, 0, 0, idle(0)));
      tbl.push_back(mk("rd_snoop",     1, 2'b00, 2'd0, 2'd0, 1, 1, 0, 0, act(0, 2'd0, 1, 0, 0, 2'b00, 0, 0)));
      tbl.push_back(mk("rd_mem",       1, 2'b00, 2'd0, 2'd0, 0, 0, 0, 1, act(0, 2'd0, 0, 1, 0, 2'b00, 0, 0)));
      tbl.push_back(mk("rd_done",      1, 2'b01, 2'd0, 2'd0, 0, 0, 0, 0, act(0, 2'd0, 0, 0, 0, 2'b01, 1, 0)));
      tbl.push_back(mk("rd_masked",    1, 2'b01, 2'd2, 2'd0, 0, 0, 0, 0, idle(0)));
      // BusUpgr: snoop_ack goes straight to done, memory untouched
      tbl.push_back(mk("upgr_req",     1, 2'b01, 2'd2, 2'd0, 0, 0, 0, 0, idle(0)));
      tbl.push_back(mk("upgr_snoop",   1, 2'b00, 2'd2, 2'd0, 1, 1, 0, 0, act(0, 2'd2, 1, 0, 0, 2'b00, 0, 0)));
      tbl.push_back(mk("upgr_done",    1, 2'b00, 2'd2, 2'd0, 0, 0, 0, 0, act(0, 2'd2, 0, 0, 0, 2'b01, 0, 0)));
      tbl.push_back(mk("upgr_idle",    1, 2'b00, 2'd0, 2'd0, 0, 0, 0, 0, idle(0)));
      // Tie after reset: core 0 first, then core 1 while core 0 is masked
      tbl.push_back(mk("reset2",       0, 2'b11, 2'd0, 2'd0, 0, 0, 0, 0, idle(0)));
      tbl.push_back(mk("tie_req",      1, 2'b11, 2'd0, 2'd0, 0, 0, 0, 0, idle(0)));
      tbl.push_back(mk("tie_snoop0",   1, 2'b11, 2'd0, 2'd0, 1, 0, 0, 0, act(0, 2'd0, 1, 0, 0, 2'b00, 0, 0)));
      tbl.push_back(mk("tie_mem0",     1, 2'b11, 2'd0, 2'd0, 0, 0, 0, 1, act(0, 2'd0, 0, 1, 0, 2'b00, 0, 0)));
      tbl.push_back(mk("tie_done0",    1, 2'b11, 2'd0, 2'd0, 0, 0, 0, 0, act(0, 2'd0, 0, 0, 0, 2'b01, 0, 0)));
      tbl.push_back(mk("tie_mask",     1, 2'b11, 2'd0, 2'd0, 0, 0, 0, 0, idle(0)));
      tbl.push_back(mk("tie_snoop1",   1, 2'b11, 2'd0, 2'd0, 1, 1, 0, 0, act(1, 2'd0, 1, 0, 0, 2'b00, 0, 0)));
      tbl.push_back(mk("tie_mem1",     1, 2'b11, 2'd0, 2'd0, 0, 0, 0, 1, act(1, 2'd0, 0, 1, 0, 2'b00, 0, 0)));
      tbl.push_back(mk("tie_done1",    1, 2'b11, 2'd0, 2'd0, 0, 0, 0, 0, act(1, 2'd0, 0, 0, 0, 2'b10, 1, 0)));
      tbl.push_back(mk("tie_idle",     1, 2'b00, 2'd0, 2'd0, 0, 0, 0, 0, idle(0)));
      // BusRdX with dirty snoop: flush write, never a memory read
      tbl.push_back(mk("rdx_req",      1, 2'b01, 2'd1, 2'd0, 0, 0, 0, 0, idle(0)));
      tbl.push_back(mk("rdx_snoop",    1, 2'b01, 2'd1, 2'd0, 1, 1, 1, 0, act(0, 2'd1, 1, 0, 0, 2'b00, 0, 0)));
      tbl.push_back(mk("rdx_flush",    1, 2'b00, 2'd0, 2'd0, 0, 0, 0, 0, act(0, 2'd1, 0, 1, 1, 2'b00, 0, 0)));
      tbl.push_back(mk("rdx_flush_rdy",1, 2'b00, 2'd0, 2'd0, 0, 0, 0, 1, act(0, 2'd1, 0, 1, 1, 2'b00, 0, 0)));
      tbl.push_back(mk("rdx_done",     1, 2'b00, 2'd0, 2'd0, 0, 0, 0, 0, act(0, 2'd1, 0, 0, 0, 2'b01, 0, 0)));
      tbl.push_back(mk("rdx_idle",     1, 2'b00, 2'd0, 2'd0, 0, 0, 0, 0, idle(0)));

      foreach (tbl[i]) apply(tbl[i]);

      // Snoop timeout: 15 silent SNOOP cycles (mem_ready ignored there), then MEM with sticky error
      apply(mk("to_req", 1, 2'b10, 2'd0, 2'd0, 0, 0, 0, 0, idle(0)));
      for (int i = 1; i <= 15; i++)
         apply(mk($sformatf("to_snoop%0d", i), 1, 2'b10, 2'd0, 2'd0, 0, 0, 0, 1,
                  act(1, 2'd0, 1, 0, 0, 2'b00, 0, 0)));
      apply(mk("to_mem",     1, 2'b00, 2'd0, 2'd0, 0, 0, 0, 1, act(1, 2'd0, 0, 1, 0, 2'b00, 0, 1)));
      apply(mk("to_done",    1, 2'b00, 2'd0, 2'd0, 0, 0, 0, 0, act(1, 2'd0, 0, 0, 0, 2'b10, 0, 1)));
      apply(mk("to_sticky0", 1, 2'b00, 2'd0, 2'd0, 0, 0, 0, 0, idle(1)));
      apply(mk("to_sticky1", 1, 2'b00, 2'd0, 2'd0, 0, 0, 0, 0, idle(1)));
      apply(mk("to_reset",   0, 2'b00, 2'd0, 2'd0, 0, 0, 0, 0, idle(0)));

      // snoop_ack on the 15th cycle wins over the timeout; ack in MEM is ignored
      apply(mk("ack15_req", 1, 2'b01, 2'd0, 2'd0, 0, 0, 0, 0, idle(0)));
      for (int i = 1; i <= 14; i++)
         apply(mk($sformatf("ack15_snoop%0d", i), 1, 2'b01, 2'd0, 2'd0, 0, 0, 0, 0,
                  act(0, 2'd0, 1, 0, 0, 2'b00, 0, 0)));
      apply(mk("ack15_snoop15", 1, 2'b01, 2'd0, 2'd0, 1, 0, 0, 0, act(0, 2'd0, 1, 0, 0, 2'b00, 0, 0)));
      apply(mk("ack15_mem",     1, 2'b00, 2'd0, 2'd0, 1, 1, 1, 0, act(0, 2'd0, 0, 1, 0, 2'b00, 0, 0)));
      apply(mk("ack15_mem_rdy", 1, 2'b00, 2'd0, 2'd0, 0, 0, 0, 1, act(0, 2'd0, 0, 1, 0, 2'b00, 0, 0)));
      apply(mk("ack15_done",    1, 2'b00, 2'd0, 2'd0, 0, 0, 0, 0, act(0, 2'd0, 0, 0, 0, 2'b01, 0, 0)));
      apply(mk("ack15_idle",    1, 2'b00, 2'd0, 2'd0, 0, 0, 0, 0, idle(0)));

      // Writeback from core 1 goes straight to MEM; reset there aborts with no done
      apply(mk("wb_req",    1, 2'b10, 2'd0, 2'd3, 0, 0, 0, 0, idle(0)));
      apply(mk("wb_mem",    1, 2'b00, 2'd0, 2'd3, 0, 0, 0, 0, act(1, 2'd3, 0, 1, 1, 2'b00, 0, 0)));
      apply(mk("wb_wait",   1, 2'b00, 2'd0, 2'd3, 0, 0, 0, 0, act(1, 2'd3, 0, 1, 1, 2'b00, 0, 0)));
      apply(mk("wb_reset",  0, 2'b00, 2'd0, 2'd3, 0, 0, 0, 1, idle(0)));
      apply(mk("wb_after0", 1, 2'b00, 2'd0, 2'd0, 0, 0, 0, 1, idle(0)));
      apply(mk("wb_after1", 1, 2'b00, 2'd0, 2'd0, 0, 0, 0, 0, idle(0)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/snoop_bus_arbiter.md
SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving the width of the request and bus address.
REQ-002 The block SHALL have parameter SNOOP_TIMEOUT, default 15, giving the number of SNOOP cycles allowed without snoop_ack (range 1-15, held in a 4-bit counter).
REQ-003 The block SHALL have these ports, one per line:
  clk  in  1  system clock, all state on rising edge
  reset  in  1  one clock; reset is asynchronous and active-low
  req  in  2  per-core request level; bit0 core 0, bit1 core 1
  req_addr0, req_addr1  in  ADDR_W  per-core line address
  req_type0, req_type1  in  2  00 BusRd, 01 BusRdX, 10 BusUpgr, 11 Writeback
  gnt  out  2  one-hot grant, held for the whole transaction
  bus_valid  out  1  snoop broadcast valid
  bus_addr  out  ADDR_W  latched address of the granted request
  bus_type  out  2  latched type of the granted request
  bus_src  out  1  index of the granted core
  snoop_ack  in  1  non-requesting core has finished its snoop
  snoop_hit  in  1  non-requesting core held the line, valid with snoop_ack
  snoop_dirty  in  1  non-requesting core held the line in MODIFIED, valid with snoop_ack
  mem_req  out  1  memory access request
  mem_we  out  1  1 = write to memory, 0 = read from memory
  mem_ready  in  1  memory access completes this cycle
  done  out  2  one-cycle completion pulse to the granted core
  resp_shared  out  1  requester fills the line in SHARED (else EXCLUSIVE/MODIFIED), valid with done
  busy  out  1  state is not IDLE
  err_timeout  out  1  sticky: a snoop timeout has occurred

Function
REQ-004 The FSM SHALL have the states IDLE, SNOOP, FLUSH, MEM and DONE, all registered, with every output a function of the registered state and registers only.
REQ-005 In IDLE with any unmasked req bit set, the block SHALL latch the addr and type of the winning core, set bus_src, and go to SNOOP, except that a Writeback goes directly to MEM.
REQ-006 Arbitration SHALL be round-robin: a single request is granted; when both cores request, the core that is not the last-served core is granted; last_served resets to 1 so that core 0 wins the first tie.
REQ-007 gnt SHALL equal onehot(bus_src) in SNOOP, FLUSH, MEM and DONE, and SHALL be 00 in IDLE.
REQ-008 bus_valid SHALL be 1 only in SNOOP; bus_addr and bus_type SHALL remain stable from grant until the block returns to IDLE.
REQ-009 SNOOP with snoop_ack=1 SHALL transition as follows:
  dirty=1 -> FLUSH
  BusUpgr, or dirty=0 with hit=1 and BusRdX -> DONE
  all other cases -> MEM
REQ-010 FLUSH SHALL assert mem_req=1 and mem_we=1 until mem_ready; on mem_ready it SHALL go to DONE (the data is supplied cache-to-cache, so there is no memory read).
REQ-011 MEM SHALL assert mem_req=1, with mem_we=1 for a Writeback and 0 otherwise; on mem_ready it SHALL go to DONE; with mem_ready low the block SHALL wait indefinitely.
REQ-012 DONE SHALL last exactly 1 cycle, set done=onehot(bus_src), and return to IDLE.
REQ-013 In DONE, resp_shared SHALL be (type==BusRd) AND the latched snoop_hit.
REQ-014 In DONE, last_served SHALL be updated to bus_src.
REQ-015 In the IDLE cycle immediately after DONE, the req bit of the just-served core SHALL be masked for that one cycle only, so that a stale req is not re-granted.
REQ-016 The 4-bit watchdog SHALL clear on SNOOP entry and increment each SNOOP cycle without snoop_ack.
REQ-017 When the watchdog reaches SNOOP_TIMEOUT, the block SHALL take the no-hit/no-dirty path (to MEM) and set err_timeout.
REQ-018 If snoop_ack arrives in the same cycle as the timeout, snoop_ack SHALL win and err_timeout SHALL not be set.
REQ-019 Deassertion of req mid-transaction SHALL be ignored: the transaction completes and done still pulses.
REQ-020 snoop_ack and mem_ready SHALL be ignored in any state other than SNOOP and FLUSH/MEM respectively.

Reset
REQ-021 On reset low, the block SHALL asynchronously enter IDLE and clear all registers: gnt=00, bus_valid=0, bus_addr=0, bus_type=0, bus_src=0, mem_req=0, mem_we=0, done=00, resp_shared=0, busy=0, err_timeout=0, last_served=1, watchdog=0, mask=0.
REQ-022 A reset asserted mid-transaction SHALL abort the transaction with no done pulse; after reset release, the first edge SHALL evaluate IDLE.

Verification
REQ-023 The bench SHALL cover a BusRd shared hit: req=01 (type 00, addr 0x40) at cycle 0, snoop_ack=1/hit=1/dirty=0 at cycle 1, mem_ready at cycle 2 -> gnt=01 and bus_valid at cycle 1, mem_req/mem_we=0 at cycle 2, done=01 with resp_shared=1 at cycle 3, IDLE at cycle 4.
REQ-024 The bench SHALL cover a tie: req=11 after reset -> core 0 served first; with both requests held, core 1 is granted next; core 0 is not re-granted in the masked IDLE cycle.
REQ-025 The bench SHALL cover BusRdX with a dirty snoop: snoop_dirty=1 -> FLUSH with mem_we=1; mem_ready -> done=onehot(src) and resp_shared=0; no MEM state is visited.
REQ-026 The bench SHALL cover BusUpgr: snoop_ack -> DONE directly; mem_req stays 0 for the whole transaction.
REQ-027 The bench SHALL cover snoop timeout: BusRd with snoop_ack never asserted -> after 15 SNOOP cycles the block goes to MEM, err_timeout=1 and stays 1 until reset; a second test asserts snoop_ack on the 15th cycle -> err_timeout stays 0.
REQ-028 The bench SHALL cover a Writeback from core 1 followed by reset asserted in the MEM state: the block goes straight to MEM with mem_we=1; on reset all outputs are 0, busy=0, and no done pulse is produced.
